// File: rtl/integral_image_builder.sv
// Purpose: streams one pyramid level in raster order and emits its inclusive integral image
//          (optional SQUARED_INTEGRAL_EN adds a 64-bit sum-of-squares path on sq_ii_out).
// Latency: 1 cycle from pixel accept to ii_valid. Backpressure: pixel_ready drops while ii_out is stalled.

`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 640
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 480
`endif

module integral_image_builder #(
   parameter int WIDTH_LIMIT  = `LAPTOP_WIDTH,
   parameter int HEIGHT_LIMIT = `LAPTOP_HEIGHT,
   parameter int PIX_W        = 32,
   localparam int XW = (WIDTH_LIMIT  > 1) ? $clog2(WIDTH_LIMIT)  : 1,
   localparam int YW = (HEIGHT_LIMIT > 1) ? $clog2(HEIGHT_LIMIT) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [PIX_W-1:0] pixel_in,
   input  logic             pixel_valid,
   output logic             pixel_ready,
   output logic [31:0]      ii_out,
   output logic             ii_valid,
   input  logic             ii_ready,
   output logic [XW-1:0]    ii_x,
   output logic [YW-1:0]    ii_y,
   output logic             busy,
   output logic             frame_done
`ifdef SQUARED_INTEGRAL_EN
   ,
   output logic [63:0]      sq_ii_out
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [XW-1:0] X_LAST = XW'(WIDTH_LIMIT - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT_LIMIT - 1);

   state_t          state, state_n;
   logic [XW-1:0]   in_x;
   logic [YW-1:0]   in_y;
   logic [31:0]     row_sum;
   logic            last_pixel_taken;
   logic [31:0]     col [WIDTH_LIMIT];

   logic [31:0]     g;
   logic [31:0]     row_sum_n;
   logic [31:0]     col_n;
   logic            take;
   logic            last_out_acc;
   logic            unused_pix;

   // Upper pixel bits carry no grayscale information.
   assign unused_pix = ^pixel_in;
   assign g          = {24'd0, pixel_in[7:0]};
   assign take       = pixel_valid & pixel_ready;
   assign last_out_acc = ii_valid & ii_ready & (ii_x == X_LAST) & (ii_y == Y_LAST);

   // Running sums: row 0 ignores the (unreset) column buffer, column 0 restarts the row sum.
   assign row_sum_n = ((in_x == '0) ? 32'd0 : row_sum) + g;
   assign col_n     = ((in_y == '0) ? 32'd0 : col[in_x]) + row_sum_n;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state and control outputs.
   always_comb begin
      state_n     = state;
      busy        = 1'b0;
      frame_done  = 1'b0;
      pixel_ready = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_n = ACTIVE;
         end
         ACTIVE: begin
            busy        = 1'b1;
            pixel_ready = (~ii_valid | ii_ready) & ~last_pixel_taken;
            if (last_out_acc) state_n = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            frame_done = 1'b1;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Raster counters, row accumulator and the single output register.
   always_ff @(posedge clock) begin
      if (reset) begin
         in_x             <= '0;
         in_y             <= '0;
         row_sum          <= 32'd0;
         last_pixel_taken <= 1'b0;
         ii_valid         <= 1'b0;
         ii_out           <= 32'd0;
         ii_x             <= '0;
         ii_y             <= '0;
      end else begin
         if (state == IDLE && start) begin
            in_x             <= '0;
            in_y             <= '0;
            row_sum          <= 32'd0;
            last_pixel_taken <= 1'b0;
         end else if (take) begin
            row_sum <= row_sum_n;
            if (in_x == X_LAST) begin
               in_x <= '0;
               if (in_y == Y_LAST) last_pixel_taken <= 1'b1;
               else                in_y <= in_y + 1'b1;
            end else begin
               in_x <= in_x + 1'b1;
            end
         end
         if (take) begin
            ii_valid <= 1'b1;
            ii_out   <= col_n;
            ii_x     <= in_x;
            ii_y     <= in_y;
         end else if (ii_ready) begin
            ii_valid <= 1'b0;
         end
      end
   end

   // Column-sum buffer, intentionally left unreset.
   always_ff @(posedge clock) begin
      if (take) col[in_x] <= col_n;
   end

`ifdef SQUARED_INTEGRAL_EN
   logic [63:0] sq_row_sum;
   logic [63:0] sq_col [WIDTH_LIMIT];
   logic [15:0] g_sq16;
   logic [63:0] sq_row_sum_n;
   logic [63:0] sq_col_n;

   assign g_sq16       = 16'(pixel_in[7:0]) * 16'(pixel_in[7:0]);
   assign sq_row_sum_n = ((in_x == '0) ? 64'd0 : sq_row_sum) + {48'd0, g_sq16};
   assign sq_col_n     = ((in_y == '0) ? 64'd0 : sq_col[in_x]) + sq_row_sum_n;

   // Squared row accumulator and output, in lockstep with the linear path.
   always_ff @(posedge clock) begin
      if (reset) begin
         sq_row_sum <= 64'd0;
         sq_ii_out  <= 64'd0;
      end else begin
         if (state == IDLE && start) sq_row_sum <= 64'd0;
         else if (take)              sq_row_sum <= sq_row_sum_n;
         if (take) sq_ii_out <= sq_col_n;
      end
   end

   // Squared column buffer, unreset like the linear one.
   always_ff @(posedge clock) begin
      if (take) sq_col[in_x] <= sq_col_n;
   end
`endif

endmodule

// File: tb/tb_integral_image_builder.sv
// Bench for integral_image_builder: two instances (4x3 and 16x8) sharing stimulus, checked against
// integral images computed directly from the frame contents by double summation.
// Covers reset values, throughput, stalls, start-while-busy, mid-frame reset and grayscale masking.

module tb_integral_image_builder;

   localparam int WA = 4,  HA = 3;
   localparam int WB = 16, HB = 8;
   localparam int NMAX = WB * HB;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        pv = 1'b0;
   logic        rdy = 1'b0;
   logic [31:0] pin = 32'd0;
   int          cur = 0;

   always #5 clk = ~clk;

   logic        st_a, st_b;
   assign st_a = start && (cur == 0);
   assign st_b = start && (cur == 1);

   logic        pr_a, ov_a, busy_a, fd_a;
   logic [31:0] o_a;
   logic [1:0]  x_a, y_a;
   logic        pr_b, ov_b, busy_b, fd_b;
   logic [31:0] o_b;
   logic [3:0]  x_b;
   logic [2:0]  y_b;
`ifdef SQUARED_INTEGRAL_EN
   logic [63:0] sq_a, sq_b, c_sq;
   assign c_sq = (cur == 0) ? sq_a : sq_b;
`endif

   integral_image_builder #(.WIDTH_LIMIT(WA), .HEIGHT_LIMIT(HA), .PIX_W(32)) dut_a (
      .clock(clk), .reset(rst), .start(st_a), .pixel_in(pin), .pixel_valid(pv),
      .pixel_ready(pr_a), .ii_out(o_a), .ii_valid(ov_a), .ii_ready(rdy),
      .ii_x(x_a), .ii_y(y_a), .busy(busy_a), .frame_done(fd_a)
`ifdef SQUARED_INTEGRAL_EN
      , .sq_ii_out(sq_a)
`endif
   );

   integral_image_builder #(.WIDTH_LIMIT(WB), .HEIGHT_LIMIT(HB), .PIX_W(32)) dut_b (
      .clock(clk), .reset(rst), .start(st_b), .pixel_in(pin), .pixel_valid(pv),
      .pixel_ready(pr_b), .ii_out(o_b), .ii_valid(ov_b), .ii_ready(rdy),
      .ii_x(x_b), .ii_y(y_b), .busy(busy_b), .frame_done(fd_b)
`ifdef SQUARED_INTEGRAL_EN
      , .sq_ii_out(sq_b)
`endif
   );

   // View of whichever instance is under test.
   logic        c_pr, c_ov, c_busy, c_fd;
   logic [31:0] c_out;
   int          c_x, c_y;
   assign c_pr   = (cur == 0) ? pr_a   : pr_b;
   assign c_ov   = (cur == 0) ? ov_a   : ov_b;
   assign c_busy = (cur == 0) ? busy_a : busy_b;
   assign c_fd   = (cur == 0) ? fd_a   : fd_b;
   assign c_out  = (cur == 0) ? o_a    : o_b;
   assign c_x    = (cur == 0) ? int'(x_a) : int'(x_b);
   assign c_y    = (cur == 0) ? int'(y_a) : int'(y_b);

   int          ncmp = 0;
   int          nerr = 0;
   logic [31:0] fr   [NMAX];
   logic [31:0] rf   [NMAX];
   logic [63:0] sqrf [NMAX];

   int          rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random
   int          vld_rand = 0;
   int          abort_at = 0;
   int          poke     = 0;
   logic [31:0] first_out, last_out;
   logic [63:0] last_sq;

   function automatic int cw();
      return (cur == 0) ? WA : WB;
   endfunction

   function automatic int ch();
      return (cur == 0) ? HA : HB;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // kind 0: constant v, 1: 4y+x, 2: random; upper 24 bits always random junk.
   task automatic fill(input int kind, input int v);
      logic [31:0] r;
      logic [7:0]  g;
      for (int y = 0; y < ch(); y++)
         for (int x = 0; x < cw(); x++) begin
            r = $urandom;
            g = (kind == 0) ? 8'(v) : (kind == 1) ? 8'(4 * y + x) : r[7:0];
            r = $urandom;
            fr[y * cw() + x] = {r[31:8], g};
         end
   endtask

   // Reference integral image straight from the definition.
   task automatic build_ref();
      logic [31:0] s, g;
      logic [63:0] q;
      for (int y = 0; y < ch(); y++)
         for (int x = 0; x < cw(); x++) begin
            s = 32'd0;
            q = 64'd0;
            for (int j = 0; j <= y; j++)
               for (int i = 0; i <= x; i++) begin
                  g = {24'd0, fr[j * cw() + i][7:0]};
                  s = s + g;
                  q = q + 64'(g * g);
               end
            rf[y * cw() + x]   = s;
            sqrf[y * cw() + x] = q;
         end
   endtask

   task automatic check_reset_values();
      chk("rst_ii_valid", c_ov, 0);
      chk("rst_ii_out", c_out, 0);
      chk("rst_ii_x", c_x, 0);
      chk("rst_ii_y", c_y, 0);
      chk("rst_busy", c_busy, 0);
      chk("rst_frame_done", c_fd, 0);
      chk("rst_pixel_ready", c_pr, 0);
   endtask

   task automatic run_frame();
      int          w, h, n, pidx, oidx, fdc, last_acc;
      logic        held, acc_prev;
      logic [31:0] h_out;
      int          h_x, h_y;
      w = cw(); h = ch(); n = w * h;
      pidx = 0; oidx = 0; fdc = 0; last_acc = -10;
      held = 1'b0; acc_prev = 1'b0; h_out = 0; h_x = 0; h_y = 0;
      build_ref();
      @(posedge clk); #1;
      start = 1'b1; pv = 1'b0; rdy = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < n * 6 + 40; c++) begin
         pv    = (pidx < n) && (vld_rand == 0 || $urandom_range(0, 1) == 1);
         pin   = (pidx < n) ? fr[pidx] : $urandom;
         rdy   = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 1) == 1);
         start = (poke != 0) && (c == 3);
         @(negedge clk);
         if (c == 0) chk("busy_active", c_busy, 1);
         if (acc_prev) chk("latency_valid", c_ov, 1);
         if (held) begin
            chk("hold_out", c_out, h_out);
            chk("hold_x", c_x, h_x);
            chk("hold_y", c_y, h_y);
         end
         if (c_ov && !rdy) chk("ready_blocked", c_pr, 0);
         if (c_ov && rdy) begin
            if (oidx < n) begin
               chk("ii_out", c_out, rf[oidx]);
               chk("ii_x", c_x, oidx % w);
               chk("ii_y", c_y, oidx / w);
`ifdef SQUARED_INTEGRAL_EN
               chk("sq_ii_out", c_sq, sqrf[oidx]);
               last_sq = c_sq;
`endif
            end else begin
               chk("extra_output", oidx, n - 1);
            end
            if (oidx == 0) first_out = c_out;
            last_out = c_out;
            last_acc = c;
            oidx++;
         end
         if (c_fd) begin
            fdc++;
            chk("done_timing", c, last_acc + 1);
            chk("done_after_all", oidx, n);
         end
         acc_prev = pv && c_pr;
         if (acc_prev) pidx++;
         held  = c_ov && !rdy;
         h_out = c_out; h_x = c_x; h_y = c_y;
         if (abort_at > 0 && pidx >= abort_at) break;
         if (fdc > 0 && c >= last_acc + 4) break;
         @(posedge clk); #1;
      end
      pv = 1'b0; start = 1'b0; rdy = 1'b1;
      if (abort_at == 0) begin
         chk("out_count", oidx, n);
         chk("done_pulses", fdc, 1);
         chk("idle_after_done", c_busy, 0);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values();
      @(posedge clk); #1;
      rst = 1'b0;

      // All ones, full throughput.
      cur = 0; fill(0, 1); rdy_mode = 0; vld_rand = 0;
      run_frame();
      chk("last_all_ones", last_out, 12);

      // Ramp 4y+x, ready toggling, start pulsed mid-frame.
      fill(1, 0); rdy_mode = 1; poke = 1;
      run_frame();
      chk("last_ramp", last_out, 66);
      poke = 0;

      // Random pixels, random valid and ready.
      fill(2, 0); rdy_mode = 2; vld_rand = 1;
      run_frame();

      // Reset in the middle of row 1, then a clean frame.
      fill(2, 0); abort_at = WA + 2;
      run_frame();
      abort_at = 0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_reset_values();

      // Upper bits all ones on the first pixel.
      fill(2, 0); fr[0] = 32'hFFFF_FF05; rdy_mode = 0; vld_rand = 0;
      run_frame();
      chk("first_masked", first_out, 5);

      // All twos.
      fill(0, 2); rdy_mode = 2;
      run_frame();
      chk("last_all_twos", last_out, 24);
`ifdef SQUARED_INTEGRAL_EN
      chk("last_sq_all_twos", last_sq, 48);
`endif

      // Larger instance: saturated pixels, then random.
      cur = 1; fill(0, 255); rdy_mode = 2; vld_rand = 1;
      run_frame();
      chk("last_all_255", last_out, 255 * WB * HB);
      fill(2, 0); rdy_mode = 1; vld_rand = 0;
      run_frame();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
